// File: rtl/dbus_timer.sv
// Memory-mapped prescaled 32-bit timer responding on the core data bus.
// Optional auto-reload on compare match: define DBUS_TIMER_AUTORELOAD_EN.
module dbus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0800,
    parameter int          PRESC_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dce,
    input  logic [31:0] daddr,
    input  logic [3:0]  we,
    input  logic [31:0] din,
    output logic [31:0] dm,
    output logic        irq
);

    logic               en_q, ie_q, auto_q;
    logic [PRESC_W-1:0] presc_q, psc_q;
    logic [31:0]        count_q, compare_q;
    logic               match_q, ovf_q;

    logic               sel, wr, rd;
    logic [1:0]         off;
    logic [31:0]        lane_mask;
    logic               ctrl_wr, count_wr, compare_wr, status_wr;
    logic [31:0]        ctrl_img, rdata;
    logic               tick, hit;
    logic [31:0]        count_inc;

    logic               en_d, ie_d;
    logic [PRESC_W-1:0] presc_d, psc_d;
    logic [31:0]        count_d, compare_d;
    logic               match_d, ovf_d, irq_d;

    logic               unused_addr_bits;
    assign unused_addr_bits = ^daddr[1:0];

    assign sel = dce && (daddr[31:4] == BASE_ADDR[31:4]);
    assign off = daddr[3:2];
    assign wr  = sel && (we != 4'b0000);
    assign rd  = sel && (we == 4'b0000);

    assign lane_mask  = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    assign ctrl_wr    = wr && (off == 2'd0);
    assign count_wr   = wr && (off == 2'd1);
    assign compare_wr = wr && (off == 2'd2);
    assign status_wr  = wr && (off == 2'd3) && we[0];

    assign tick      = en_q && (psc_q == presc_q);
    assign count_inc = count_q + 32'd1;
    assign hit       = tick && !count_wr && (count_inc == compare_q);

    always_comb begin
        ctrl_img                = '0;
        ctrl_img[0]             = en_q;
        ctrl_img[1]             = ie_q;
        ctrl_img[2]             = auto_q;
        ctrl_img[8 +: PRESC_W]  = presc_q;

        rdata = '0;
        case (off)
            2'd0: rdata = ctrl_img;
            2'd1: rdata = count_q;
            2'd2: rdata = compare_q;
            2'd3: rdata = {30'd0, ovf_q, match_q};
        endcase
    end

    always_comb begin
        en_d    = en_q;
        ie_d    = ie_q;
        presc_d = presc_q;
        if (ctrl_wr && we[0]) begin
            en_d = din[0];
            ie_d = din[1];
        end
        for (int i = 0; i < PRESC_W; i++) begin
            if (ctrl_wr && lane_mask[8+i])
                presc_d[i] = din[8+i];
        end

        compare_d = compare_wr ? ((compare_q & ~lane_mask) | (din & lane_mask)) : compare_q;

        // A bus write to COUNT wins over the increment and restarts the prescaler
        count_d = count_q;
        if (count_wr)
            count_d = (count_q & ~lane_mask) | (din & lane_mask);
        else if (tick)
            count_d = (auto_q && hit) ? 32'd0 : count_inc;

        psc_d = (count_wr || !en_q || tick) ? '0 : psc_q + PRESC_W'(1);

        // Set events beat a same-cycle write-1-to-clear
        match_d = hit || (match_q && !(status_wr && din[0]));
        ovf_d   = (tick && !count_wr && (count_q == 32'hFFFF_FFFF))
                  || (ovf_q && !(status_wr && din[1]));

        irq_d = ie_d && match_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= 1'b0;
            ie_q      <= 1'b0;
            presc_q   <= '0;
            psc_q     <= '0;
            count_q   <= 32'd0;
            compare_q <= 32'hFFFF_FFFF;
            match_q   <= 1'b0;
            ovf_q     <= 1'b0;
            irq       <= 1'b0;
            dm        <= 32'd0;
        end else begin
            en_q      <= en_d;
            ie_q      <= ie_d;
            presc_q   <= presc_d;
            psc_q     <= psc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            match_q   <= match_d;
            ovf_q     <= ovf_d;
            irq       <= irq_d;
            dm        <= rd ? rdata : 32'd0;
        end
    end

`ifdef DBUS_TIMER_AUTORELOAD_EN
    always_ff @(posedge clk) begin
        if (rst)
            auto_q <= 1'b0;
        else if (ctrl_wr && we[0])
            auto_q <= din[2];
    end
`else
    assign auto_q = 1'b0;
`endif

endmodule

// File: tb/tb_dbus_timer.sv
// Bench for dbus_timer: directed scenarios plus randomized bus traffic
// compared every cycle against a behavioural register-level model.
module tb_dbus_timer;

    localparam logic [31:0] BASE = 32'h0000_0800;
`ifdef DBUS_TIMER_AUTORELOAD_EN
    localparam bit AUTO_IMPL = 1'b1;
`else
    localparam bit AUTO_IMPL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dce = 1'b0;
    logic [31:0] daddr = '0;
    logic [3:0]  we = '0;
    logic [31:0] din = '0;
    logic [31:0] dm;
    logic        irq;

    int checks = 0;
    int errors = 0;

    dbus_timer #(.BASE_ADDR(BASE), .PRESC_W(8)) dut (
        .clk(clk), .rst(rst), .dce(dce), .daddr(daddr),
        .we(we), .din(din), .dm(dm), .irq(irq)
    );

    always #5 clk = ~clk;

    // model state
    logic        m_en, m_ie, m_auto, m_match, m_ovf, m_irq;
    logic [7:0]  m_presc, m_pc;
    logic [31:0] m_count, m_compare, m_dm;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] lanes);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (lanes[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_edge();
        logic        s, w, r, t, hit, wrap;
        logic [1:0]  o;
        logic [31:0] ctrl, vals [4], nctrl, ncount, ncompare;
        logic        nmatch, novf;
        logic [7:0]  npc;
        if (rst) begin
            m_en = 0; m_ie = 0; m_auto = 0; m_presc = 0; m_pc = 0;
            m_count = 0; m_compare = 32'hFFFF_FFFF; m_match = 0; m_ovf = 0;
            m_irq = 0; m_dm = 0;
            return;
        end
        s = dce && (daddr[31:4] == BASE[31:4]);
        o = daddr[3:2];
        w = s && (we != 0);
        r = s && (we == 0);
        ctrl = {16'd0, m_presc, 5'd0, m_auto, m_ie, m_en};
        vals[0] = ctrl; vals[1] = m_count; vals[2] = m_compare; vals[3] = {30'd0, m_ovf, m_match};

        nctrl    = (w && o == 0) ? merge(ctrl, din, we) : ctrl;
        ncompare = (w && o == 2) ? merge(m_compare, din, we) : m_compare;
        nmatch   = m_match;
        novf     = m_ovf;
        if (w && o == 3 && we[0]) begin
            if (din[0]) nmatch = 0;
            if (din[1]) novf = 0;
        end

        t = m_en && (m_pc == m_presc);
        ncount = m_count;
        if (w && o == 1) begin
            ncount = merge(m_count, din, we);
            npc = 0;
        end else if (t) begin
            hit  = (m_count + 32'd1) == m_compare;
            wrap = (m_count == 32'hFFFF_FFFF);
            ncount = (m_auto && hit) ? 32'd0 : m_count + 32'd1;
            if (hit)  nmatch = 1;
            if (wrap) novf = 1;
            npc = 0;
        end else begin
            npc = m_en ? m_pc + 8'd1 : 8'd0;
        end

        m_dm      = r ? vals[o] : 32'd0;
        m_en      = nctrl[0];
        m_ie      = nctrl[1];
        m_auto    = AUTO_IMPL ? nctrl[2] : 1'b0;
        m_presc   = nctrl[15:8];
        m_pc      = npc;
        m_count   = ncount;
        m_compare = ncompare;
        m_match   = nmatch;
        m_ovf     = novf;
        m_irq     = m_ie && m_match;
    endtask

    task automatic bus(input logic c, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        dce = c; daddr = a; we = w; din = d;
        model_edge();
        @(posedge clk);
        #1;
        check_val("dm", dm, m_dm);
        check_val("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic idle();
        bus(1'b0, 32'd0, 4'd0, 32'd0);
    endtask

    task automatic wr(input logic [3:0] o, input logic [31:0] d);
        bus(1'b1, BASE + {28'd0, o}, 4'hF, d);
    endtask

    task automatic rd_exp(input logic [3:0] o, input logic [31:0] exp, input string tag);
        bus(1'b1, BASE + {28'd0, o}, 4'h0, 32'd0);
        check_val(tag, dm, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        rst = 1'b0;
    endtask

    logic [31:0] seq_exp [7];

    initial begin
        // reset values
        do_reset();
        check_val("rst_irq", {31'd0, irq}, 32'd0);
        rd_exp(4'h0, 32'd0, "rst_ctrl");
        rd_exp(4'h4, 32'd0, "rst_count");
        rd_exp(4'h8, 32'hFFFF_FFFF, "rst_compare");
        rd_exp(4'hC, 32'd0, "rst_status");

        // compare match and interrupt
        do_reset();
        wr(4'h8, 32'd5);
        wr(4'h0, 32'h0000_0003);
        repeat (4) idle();
        check_val("irq_before_match", {31'd0, irq}, 32'd0);
        idle();
        check_val("irq_at_match", {31'd0, irq}, 32'd1);
        rd_exp(4'hC, 32'd1, "status_match");

        // prescaler and byte-lane write
        do_reset();
        wr(4'h0, 32'h0000_0301);
        wr(4'h4, 32'd0);
        repeat (8) idle();
        rd_exp(4'h4, 32'd2, "presc_count");
        bus(1'b1, BASE, 4'b0010, 32'h0000_0100);
        rd_exp(4'h0, 32'h0000_0101, "byte_lane_ctrl");

        // overflow and W1C
        do_reset();
        wr(4'h8, 32'h10);
        wr(4'h0, 32'h1);
        wr(4'h4, 32'hFFFF_FFFE);
        idle();
        idle();
        rd_exp(4'hC, 32'd2, "ovf_set");
        bus(1'b1, BASE + 32'hC, 4'b0001, 32'd2);
        rd_exp(4'hC, 32'd0, "ovf_cleared");
        wr(4'h4, 32'hFFFF_FFFF);
        bus(1'b1, BASE + 32'hC, 4'b0001, 32'd2);
        rd_exp(4'hC, 32'd2, "ovf_set_beats_clear");

        // unmapped / unselected
        bus(1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF);
        check_val("unmapped_wr_dm", dm, 32'd0);
        bus(1'b0, BASE, 4'hF, 32'h0000_FF06);
        check_val("dce0_wr_dm", dm, 32'd0);
        bus(1'b1, BASE + 32'h10, 4'h0, 32'd0);
        check_val("unmapped_rd_dm", dm, 32'd0);
        rd_exp(4'h0, 32'h1, "ctrl_untouched");
        rd_exp(4'h8, 32'h10, "compare_untouched");

        // auto-reload or free-run
        do_reset();
        wr(4'h8, 32'd3);
        wr(4'h0, 32'd7);
        if (AUTO_IMPL) begin
            seq_exp = '{32'd0, 32'd1, 32'd2, 32'd0, 32'd1, 32'd2, 32'd0};
        end else begin
            seq_exp = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        end
        for (int k = 0; k < 7; k++)
            rd_exp(4'h4, seq_exp[k], "count_seq");
        rd_exp(4'h0, AUTO_IMPL ? 32'd7 : 32'd3, "ctrl_auto_bit");

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic        c;
            logic [31:0] a, d;
            logic [3:0]  w;
            rst = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 7) != 0);
            a = ($urandom_range(0, 3) != 0) ? BASE + {28'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))}
                                            : $urandom;
            w = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            d = $urandom;
            case (a[3:2])
                2'd0: d[15:10] = 6'd0;
                2'd1: if ($urandom_range(0, 1) == 0) d = 32'hFFFF_FFFF - $urandom_range(0, 6);
                      else d = $urandom_range(0, 8);
                2'd2: d = $urandom_range(0, 12);
                default: ;
            endcase
            bus(c, a, w, d);
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
